// File: rtl/csam_seq_pkg.sv
// Shared types and constants for the sequential multiplier built on the 4x4 CSAM array.
package csam_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int NUM_STEPS = 4;

  // Left shift applied to each step's nibble product: XL*YL, XH*YL, XL*YH, XH*YH
  localparam logic [3:0] STEP_SHIFT [NUM_STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

  // Step-counter bit that selects the high nibble of each operand
  localparam int X_HI_BIT = 0;
  localparam int Y_HI_BIT = 1;

  function automatic logic [3:0] nibble(input logic [7:0] v, input logic hi);
    return hi ? v[7:4] : v[3:0];
  endfunction

endpackage

// File: rtl/csam8_seq_csam.sv
// 4x4 unsigned carry-save array multiplier: three carry-save rows, ripple final add.
module csam8_seq_csam (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] s;
  logic [3:0] c;
  logic [3:0] sh;
  logic [3:0] pp;
  logic [3:0] sn;
  logic [3:0] cn;

  // Each row folds one partial-product row into the sum/carry vectors; s[j] and
  // c[j] sit at weights i+j and i+j+1, so the LSB of s retires one product bit per row.
  always_comb begin
    s  = a & {4{b[0]}};
    c  = '0;
    p  = '0;
    sh = '0;
    pp = '0;
    sn = '0;
    cn = '0;
    for (int i = 1; i < 4; i++) begin
      p[i-1] = s[0];
      sh     = {1'b0, s[3:1]};
      pp     = a & {4{b[i]}};
      sn     = pp ^ sh ^ c;
      cn     = (pp & sh) | (pp & c) | (sh & c);
      s      = sn;
      c      = cn;
    end
    p[3]   = s[0];
    // 15*15 fits in 8 bits, so the final ripple add has no carry-out
    p[7:4] = {1'b0, s[3:1]} + c;
  end

endmodule

// File: rtl/csam8_seq.sv
// Sequential 8x8 unsigned multiplier that time-shares one 4x4 CSAM array over four
// nibble products and returns the 16-bit result on a valid/ready response port.
module csam8_seq
  import csam_seq_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_p,
  output logic        busy
);

  seq_state_t  state;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [7:0]  x_r;
  logic [7:0]  y_r;

  logic [3:0]  xn;
  logic [3:0]  yn;
  logic [7:0]  z8;
  logic [15:0] term;
  logic        zero_op;

  // Nibble mux feeding the shared array, and the shifted product for this step
  always_comb begin
    xn   = nibble(x_r, step[X_HI_BIT]);
    yn   = nibble(y_r, step[Y_HI_BIT]);
    term = {8'd0, z8} << STEP_SHIFT[step];
  end

  csam8_seq_csam u_csam (
    .a (xn),
    .b (yn),
    .p (z8)
  );

  assign zero_op = (req_x == 8'd0) || (req_y == 8'd0);

  // Handshake flags come from the state register alone so they never follow inputs
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state == MUL) || (state == DONE);
  assign resp_p     = acc;

  // Control FSM with operand capture and shift-accumulate; reset abandons any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= 2'd0;
      acc   <= 16'd0;
      x_r   <= 8'd0;
      y_r   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_r  <= req_x;
            y_r  <= req_y;
            acc  <= 16'd0;
            step <= 2'd0;
            if (ZERO_SKIP && zero_op) state <= DONE;
            else                      state <= MUL;
          end
        end
        MUL: begin
          // 0xFF*0xFF = 0xFE01, so the 16-bit sum never wraps
          acc  <= acc + term;
          step <= step + 2'd1;
          if (step == 2'd3) state <= DONE;
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csam8_seq.sv
// Directed and randomized bench for csam8_seq, with ZERO_SKIP off and on.
module tb_csam8_seq;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [7:0]  req_x, req_y;
  logic [15:0] resp_p;

  logic        req_valid_z, req_ready_z, resp_valid_z, resp_ready_z, busy_z;
  logic [7:0]  req_x_z, req_y_z;
  logic [15:0] resp_p_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csam8_seq #(.ZERO_SKIP(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_p(resp_p), .busy(busy)
  );

  csam8_seq #(.ZERO_SKIP(1'b1)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_x(req_x_z), .req_y(req_y_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z), .resp_p(resp_p_z), .busy(busy_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the main DUT and return just after its accepting edge
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    tick();
    req_valid = 1'b0;
  endtask

  // Count edges after the accept until resp_valid shows (bounded)
  task automatic wait_resp(output int edges);
    edges = 0;
    while (!resp_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_x = 8'd0; req_y = 8'd0; resp_ready = 1'b0;
    req_valid_z = 1'b0; req_x_z = 8'd0; req_y_z = 8'd0; resp_ready_z = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++;
    if (resp_p !== 16'h0000) begin errors++; $display("FAIL reset_resp_p got %h exp 0000", resp_p); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int e;
    resp_ready = 1'b1;
    issue(8'h12, 8'h34);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy=%b req_ready=%b exp 1/0", busy, req_ready);
    end
    wait_resp(e);
    checks++;
    if (e != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", e); end
    checks++;
    if (resp_p !== 16'h03A8) begin errors++; $display("FAIL basic_product got %h exp 03a8", resp_p); end
    tick();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return got req_ready=%b resp_valid=%b exp 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_products();
    logic [7:0]  xs [3] = '{8'hFF, 8'h80, 8'h0F};
    logic [7:0]  ys [3] = '{8'hFF, 8'h02, 8'hF0};
    logic [15:0] ps [3] = '{16'hFE01, 16'h0100, 16'h0E10};
    int e;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(xs[i], ys[i]);
      wait_resp(e);
      checks++;
      if (resp_p !== ps[i] || e != 4) begin
        errors++; $display("FAIL product_%0d got %h after %0d edges exp %h after 4", i, resp_p, e, ps[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    resp_ready = 1'b0;
    issue(8'hA5, 8'h5A);
    wait_resp(e);
    checks++;
    if (resp_p !== 16'h3A02 || e != 4) begin
      errors++; $display("FAIL bp_product got %h after %0d edges exp 3a02 after 4", resp_p, e);
    end
    // Next request held while the response is stalled; it must not be taken
    req_valid = 1'b1; req_x = 8'h11; req_y = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_p !== 16'h3A02 || busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b p=%h busy=%b ready=%b exp 1/3a02/1/0",
                 i, resp_valid, resp_p, busy, req_ready);
      end
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b busy=%b valid=%b exp 1/0/0", req_ready, busy, resp_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy=%b exp 1", busy); end
    wait_resp(e);
    checks++;
    if (resp_p !== 16'h0121 || e != 4) begin
      errors++; $display("FAIL bp_next_product got %h after %0d edges exp 0121 after 4", resp_p, e);
    end
    tick();
  endtask

  task automatic test_zero_skip();
    int e;
    resp_ready_z = 1'b1;
    // Non-zero request still takes the full array path
    req_valid_z = 1'b1; req_x_z = 8'h12; req_y_z = 8'h34;
    tick();
    req_valid_z = 1'b0;
    e = 0;
    while (!resp_valid_z && e < 20) begin tick(); e++; end
    checks++;
    if (resp_p_z !== 16'h03A8 || e != 4) begin
      errors++; $display("FAIL zs_nonzero got %h after %0d edges exp 03a8 after 4", resp_p_z, e);
    end
    tick();
    // Zero operand: DONE straight from the accepting edge
    req_valid_z = 1'b1; req_x_z = 8'h00; req_y_z = 8'hAB;
    tick();
    req_valid_z = 1'b0;
    checks++;
    if (resp_valid_z !== 1'b1 || resp_p_z !== 16'h0000 || busy_z !== 1'b1) begin
      errors++; $display("FAIL zs_skip got valid=%b p=%h busy=%b exp 1/0000/1", resp_valid_z, resp_p_z, busy_z);
    end
    tick();
    checks++;
    if (req_ready_z !== 1'b1) begin errors++; $display("FAIL zs_return got %b exp 1", req_ready_z); end
    // Same request without the skip goes the long way
    resp_ready = 1'b1;
    issue(8'h00, 8'hAB);
    wait_resp(e);
    checks++;
    if (resp_p !== 16'h0000 || e != 4) begin
      errors++; $display("FAIL nozs_zero got %h after %0d edges exp 0000 after 4", resp_p, e);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int e;
    int seen = 0;
    resp_ready = 1'b1;
    issue(8'h37, 8'h91);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_p !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset got busy=%b ready=%b valid=%b p=%h exp 0/1/0/0000",
               busy, req_ready, resp_valid, resp_p);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL async_no_resp got %0d valid cycles exp 0", seen); end
    issue(8'h37, 8'h91);
    wait_resp(e);
    checks++;
    if (resp_p !== 16'h1F27 || e != 4) begin
      errors++; $display("FAIL async_retry got %h after %0d edges exp 1f27 after 4", resp_p, e);
    end
    tick();
  endtask

  task automatic test_random();
    int          n;
    int          handshakes = 0;
    logic        got;
    logic [7:0]  x, y;
    logic [15:0] expv;
    for (int k = 0; k < 500; k++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      expv = 16'(x) * 16'(y);
      issue(x, y);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        resp_ready = ($urandom_range(0, 3) != 0);
        if (resp_valid && resp_ready) begin
          got = 1'b1;
          handshakes++;
          checks++;
          if (resp_p !== expv) begin
            errors++; $display("FAIL rand_%0d got %h exp %h (x=%h y=%h)", k, resp_p, expv, x, y);
          end
        end
        tick();
        n++;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_timeout_%0d got no response exp %h", k, expv);
      end
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL rand_dup_%0d got valid=%b after handshake exp 0", k, resp_valid);
      end
    end
    checks++;
    if (handshakes != 500) begin errors++; $display("FAIL rand_count got %0d exp 500", handshakes); end
    resp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_back_to_back();
    test_zero_skip();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
